// File: rtl/bullet_control_pkg.sv
// Shared game constants for the skill-2 bullet engine: grid geometry,
// bullet FSM encodings and screen positions.
package bullet_control_pkg;

  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 24;
  localparam int CELL_W    = 32;
  localparam int CELL_H    = 20;
  localparam int CELL_BITS = 3;

  localparam logic [9:0] PARK_Y   = 10'd700;
  localparam logic [9:0] PADDLE_Y = 10'd467;

  localparam logic [1:0] ST_PARK = 2'd0;
  localparam logic [1:0] ST_FLY  = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;

  // Linear cell index c + 20*r; r never exceeds GRID_ROWS-1 so 9 bits suffice.
  function automatic logic [8:0] cell_idx(input logic [4:0] col, input logic [4:0] row);
    return 9'(col) + 9'(row) * 9'(GRID_COLS);
  endfunction

endpackage

// File: rtl/bullet_unit.sv
// One bullet: PARK/FLY/HIT state machine, col/row/x registers and the
// lookup of the brick cell directly above its current row.
module bullet_unit
  import bullet_control_pkg::*;
#(
  parameter logic [9:0] X_RST      = 10'd250,
  parameter int         LAUNCH_ROW = 23,
  parameter logic [9:0] PARK_Y_P   = PARK_Y
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          park_i,
  input  logic                                          launch_i,
  input  logic [9:0]                                    launch_x_i,
  input  logic                                          tick_i,
  input  logic                                          accept_i,
  input  logic [GRID_COLS*GRID_ROWS*CELL_BITS-1:0]      bricks_i,
  output logic [1:0]                                    state_o,
  output logic                                          hit_o,
  output logic [9:0]                                    x_o,
  output logic [9:0]                                    y_o,
  output logic [8:0]                                    idx_o
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [9:0]  x_q, x_d;
  logic [4:0]  row_m1;
  logic [10:0] cell_base;
  logic        cell_nz;

  // Row 0 never looks up (it parks), so clamp to keep the index in range.
  assign row_m1    = (row_q == 5'd0) ? 5'd0 : row_q - 5'd1;
  assign cell_base = 11'(cell_idx(col_q, row_m1)) * 11'(CELL_BITS);
  assign cell_nz   = |bricks_i[cell_base +: CELL_BITS];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    if (park_i) begin
      state_d = ST_PARK;
      x_d     = X_RST;
    end else if (launch_i) begin
      state_d = ST_FLY;
      x_d     = launch_x_i;
      col_d   = launch_x_i[9:5];
      row_d   = 5'(LAUNCH_ROW);
    end else begin
      case (state_q)
        ST_FLY: begin
          if (tick_i) begin
            if (row_q == 5'd0) begin
              state_d = ST_PARK;
              x_d     = X_RST;
            end else begin
              row_d   = row_m1;
              state_d = cell_nz ? ST_HIT : ST_FLY;
            end
          end
        end
        ST_HIT: begin
          if (accept_i) begin
            state_d = ST_PARK;
            x_d     = X_RST;
          end
        end
        default: state_d = ST_PARK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PARK;
      col_q   <= 5'd0;
      row_q   <= 5'd0;
      x_q     <= X_RST;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= x_d;
    end
  end

  assign state_o = state_q;
  assign hit_o   = (state_q == ST_HIT);
  assign x_o     = x_q;
  assign y_o     = (state_q == ST_PARK) ? PARK_Y_P : 10'(row_q) * 10'(CELL_H);
  assign idx_o   = cell_idx(col_q, row_q);

endmodule

// File: rtl/bullet_control.sv
// Skill-2 projectile engine: launches two bullets from the paddle ends and
// arbitrates their brick-clear requests onto one valid/ready port.
module bullet_control
  import bullet_control_pkg::*;
#(
  parameter int         BOARD_W    = 100,
  parameter int         LAUNCH_ROW = 23,
  parameter logic [9:0] PARK_Y_P   = PARK_Y
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     tick,
  input  logic                                     active,
  input  logic                                     fire,
  input  logic [9:0]                               board_x,
  input  logic [GRID_COLS*GRID_ROWS*CELL_BITS-1:0] bricks,
  output logic [9:0]                               bulletA_x,
  output logic [9:0]                               bulletA_y,
  output logic [9:0]                               bulletB_x,
  output logic [9:0]                               bulletB_y,
  output logic                                     busy,
  output logic                                     clr_valid,
  output logic [8:0]                               clr_idx,
  input  logic                                     clr_ready
);

  // Clear handshake: clr_idx is held while clr_valid & ~clr_ready; a transfer
  // happens on clr_valid & clr_ready and parks the bullet that was presented.
  logic       launch, park_all;
  logic [1:0] a_state, b_state;
  logic       a_hit, b_hit;
  logic [8:0] a_idx, b_idx;
  logic       sel_b, accept_a, accept_b;
  logic       lock_b_q, lock_b_d;

  assign launch   = fire & active & ~busy;
  assign park_all = ~active;

  // Once B is on the port it stays there until accepted, even if A hits meanwhile.
  assign sel_b    = lock_b_q | ~a_hit;
  assign accept_a = clr_valid & clr_ready & ~sel_b;
  assign accept_b = clr_valid & clr_ready & sel_b;
  assign lock_b_d = active & clr_valid & ~clr_ready & sel_b;

  always_ff @(posedge clk) begin
    if (rst) lock_b_q <= 1'b0;
    else     lock_b_q <= lock_b_d;
  end

  bullet_unit #(
    .X_RST      (10'd250),
    .LAUNCH_ROW (LAUNCH_ROW),
    .PARK_Y_P   (PARK_Y_P)
  ) u_bullet_a (
    .clk        (clk),
    .rst        (rst),
    .park_i     (park_all),
    .launch_i   (launch),
    .launch_x_i (board_x + 10'd8),
    .tick_i     (tick),
    .accept_i   (accept_a),
    .bricks_i   (bricks),
    .state_o    (a_state),
    .hit_o      (a_hit),
    .x_o        (bulletA_x),
    .y_o        (bulletA_y),
    .idx_o      (a_idx)
  );

  bullet_unit #(
    .X_RST      (10'd100),
    .LAUNCH_ROW (LAUNCH_ROW),
    .PARK_Y_P   (PARK_Y_P)
  ) u_bullet_b (
    .clk        (clk),
    .rst        (rst),
    .park_i     (park_all),
    .launch_i   (launch),
    .launch_x_i (board_x + 10'(BOARD_W - 8)),
    .tick_i     (tick),
    .accept_i   (accept_b),
    .bricks_i   (bricks),
    .state_o    (b_state),
    .hit_o      (b_hit),
    .x_o        (bulletB_x),
    .y_o        (bulletB_y),
    .idx_o      (b_idx)
  );

  assign busy      = (a_state != ST_PARK) | (b_state != ST_PARK);
  assign clr_valid = a_hit | b_hit;
  assign clr_idx   = !clr_valid ? 9'd0 : (sel_b ? b_idx : a_idx);

endmodule
